// File: rtl/cnn_channel_acc_if.sv
// cnn_channel_acc_if: beat-in / pixel-out handshake bundle for the channel accumulator.
interface cnn_channel_acc_if #(
    parameter int KW    = 3,
    parameter int KH    = 3,
    parameter int IF_BW = 8,
    parameter int W_BW  = 8,
    parameter int B_BW  = 16,
    parameter int O_BW  = 16
);
    logic                     i_valid;
    logic                     i_ready;
    logic [KW*KH*IF_BW-1:0]   i_fmap;
    logic [KW*KH*W_BW-1:0]    i_weight;
    logic [B_BW-1:0]          i_bias;
    logic                     o_valid;
    logic                     o_ready;
    logic [O_BW-1:0]          o_result;
    logic                     o_busy;
    modport master (
        output i_valid, i_fmap, i_weight, i_bias, o_ready,
        input  i_ready, o_valid, o_result, o_busy
    );
    modport slave (
        input  i_valid, i_fmap, i_weight, i_bias, o_ready,
        output i_ready, o_valid, o_result, o_busy
    );
endinterface

// File: rtl/cnn_channel_acc.sv
// cnn_channel_acc: multiply a KWxKH window per channel beat, accumulate ICH channels,
// add bias, optional ReLU, saturate; 4-stage pipeline that freezes while the output stalls.
module cnn_channel_acc #(
    parameter int KW      = 3,
    parameter int KH      = 3,
    parameter int ICH     = 4,
    parameter int IF_BW   = 8,
    parameter int W_BW    = 8,
    parameter int B_BW    = 16,
    parameter int O_BW    = 16,
    parameter int RELU_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    cnn_channel_acc_if.slave  bus
);
    localparam int N     = KW * KH;
    localparam int M_BW  = IF_BW + W_BW;
    localparam int AC_BW = M_BW + $clog2(N);
    localparam int CH_BW = AC_BW + $clog2(ICH);
    localparam int BA_BW = (CH_BW > B_BW ? CH_BW : B_BW) + 1;
    localparam int CN_BW = ICH > 1 ? $clog2(ICH) : 1;
    localparam logic signed [BA_BW-1:0] O_MAX = {{(BA_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [BA_BW-1:0] O_MIN = {{(BA_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

    logic [CN_BW-1:0]        cnt_q, cnt_d;
    logic                    s1_v_q, s1_v_d, s1_f_q, s1_f_d, s1_l_q, s1_l_d;
    logic signed [M_BW-1:0]  s1_p_q [N];
    logic signed [M_BW-1:0]  s1_p_d [N];
    logic signed [B_BW-1:0]  s1_b_q, s1_b_d;
    logic                    s2_v_q, s2_v_d, s2_f_q, s2_f_d, s2_l_q, s2_l_d;
    logic signed [AC_BW-1:0] s2_sum_q, s2_sum_d, sum;
    logic signed [B_BW-1:0]  s2_b_q, s2_b_d;
    logic                    s3_v_q, s3_v_d, s3_l_q, s3_l_d;
    logic signed [CH_BW-1:0] s3_acc_q, s3_acc_d;
    logic signed [B_BW-1:0]  s3_b_q, s3_b_d;
    logic                    o_valid_q, o_valid_d;
    logic [O_BW-1:0]         o_result_q, o_result_d;
    logic                    stall, accept, first, last, fire;
    logic signed [BA_BW-1:0] ba, ba_r;

    always_comb begin
        stall  = o_valid_q && !bus.o_ready;
        accept = bus.i_valid && !stall;
        first  = cnt_q == '0;
        last   = cnt_q == CN_BW'(ICH - 1);
        cnt_d  = !accept ? cnt_q : last ? '0 : cnt_q + 1'b1;
        s1_v_d = stall ? s1_v_q : accept;
        s1_f_d = stall ? s1_f_q : first;
        s1_l_d = stall ? s1_l_q : last;
        s1_b_d = stall ? s1_b_q : bus.i_bias;
        for (int k = 0; k < N; k++)
            s1_p_d[k] = stall ? s1_p_q[k]
                      : M_BW'($signed(bus.i_fmap[k*IF_BW +: IF_BW])) * M_BW'($signed(bus.i_weight[k*W_BW +: W_BW]));
        sum = '0;
        for (int k = 0; k < N; k++)
            sum = sum + AC_BW'(s1_p_q[k]);
        s2_v_d   = stall ? s2_v_q : s1_v_q;
        s2_f_d   = stall ? s2_f_q : s1_f_q;
        s2_l_d   = stall ? s2_l_q : s1_l_q;
        s2_b_d   = stall ? s2_b_q : s1_b_q;
        s2_sum_d = stall ? s2_sum_q : sum;
        s3_v_d   = stall ? s3_v_q : s2_v_q;
        s3_l_d   = stall ? s3_l_q : s2_l_q;
        s3_b_d   = stall ? s3_b_q : s2_b_q;
        // first-tagged beats restart the pixel, so no explicit clear is needed between pixels
        s3_acc_d = (stall || !s2_v_q) ? s3_acc_q
                 : s2_f_q ? CH_BW'(s2_sum_q) : s3_acc_q + CH_BW'(s2_sum_q);
        ba   = BA_BW'(s3_acc_q) + BA_BW'(s3_b_q);
        ba_r = (RELU_EN != 0 && ba < 0) ? '0 : ba;
        fire = !stall && s3_v_q && s3_l_q;
        o_valid_d  = stall || fire;
        o_result_d = !fire ? o_result_q
                   : ba_r > O_MAX ? {1'b0, {(O_BW-1){1'b1}}}
                   : ba_r < O_MIN ? {1'b1, {(O_BW-1){1'b0}}}
                   : ba_r[O_BW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_f_q     <= 1'b0;
            s1_l_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_f_q     <= 1'b0;
            s2_l_q     <= 1'b0;
            s3_v_q     <= 1'b0;
            s3_l_q     <= 1'b0;
            s3_acc_q   <= '0;
            o_valid_q  <= 1'b0;
            o_result_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_v_q     <= s1_v_d;
            s1_f_q     <= s1_f_d;
            s1_l_q     <= s1_l_d;
            s2_v_q     <= s2_v_d;
            s2_f_q     <= s2_f_d;
            s2_l_q     <= s2_l_d;
            s3_v_q     <= s3_v_d;
            s3_l_q     <= s3_l_d;
            s3_acc_q   <= s3_acc_d;
            o_valid_q  <= o_valid_d;
            o_result_q <= o_result_d;
        end
    end

    // payload registers are qualified by the valid tags, so they need no reset
    always_ff @(posedge clk) begin
        s1_p_q   <= s1_p_d;
        s1_b_q   <= s1_b_d;
        s2_sum_q <= s2_sum_d;
        s2_b_q   <= s2_b_d;
        s3_b_q   <= s3_b_d;
    end

    assign bus.i_ready  = !stall;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_result = o_result_q;
    assign bus.o_busy   = (cnt_q != '0) || s1_v_q || s2_v_q || s3_v_q;
endmodule

// File: tb/tb_cnn_channel_acc.sv
// tb_cnn_channel_acc: three accumulator configurations share one directed stimulus stream;
// a transaction-level model predicts every output each cycle, literal results pin the model.
module tb_cnn_channel_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic ordy = 1'b1;
    logic [71:0] fm = '0;
    logic [71:0] wt = '0;
    logic [15:0] bi = '0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cnn_channel_acc_if              if0 ();
    cnn_channel_acc_if              if1 ();
    cnn_channel_acc_if #(.O_BW(8))  if2 ();

    assign {if0.i_valid, if0.i_fmap, if0.i_weight, if0.i_bias, if0.o_ready} = {vld, fm, wt, bi, ordy};
    assign {if1.i_valid, if1.i_fmap, if1.i_weight, if1.i_bias, if1.o_ready} = {vld, fm, wt, bi, ordy};
    assign {if2.i_valid, if2.i_fmap, if2.i_weight, if2.i_bias, if2.o_ready} = {vld, fm, wt, bi, ordy};

    cnn_channel_acc #(.ICH(1))                       u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    cnn_channel_acc                                  u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    cnn_channel_acc #(.ICH(1), .RELU_EN(0), .O_BW(8)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [2:0] dv, drdy, db;
    logic signed [15:0] dr [3];
    assign dv    = {if2.o_valid, if1.o_valid, if0.o_valid};
    assign drdy  = {if2.i_ready, if1.i_ready, if0.i_ready};
    assign db    = {if2.o_busy, if1.o_busy, if0.o_busy};
    assign dr[0] = $signed(if0.o_result);
    assign dr[1] = $signed(if1.o_result);
    assign dr[2] = 16'($signed(if2.o_result));

    function automatic int ich(int i);  return i == 1 ? 4 : 1; endfunction
    function automatic bit relu(int i); return i != 2;         endfunction
    function automatic int obw(int i);  return i == 2 ? 8 : 16; endfunction

    function automatic longint fin(int i, longint v);
        longint mx = (longint'(1) << (obw(i) - 1)) - 1;
        if (relu(i) && v < 0) v = 0;
        return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
    endfunction

    function automatic longint dot();
        longint s = 0;
        for (int k = 0; k < 9; k++)
            s += longint'($signed(fm[k*8 +: 8])) * longint'($signed(wt[k*8 +: 8]));
        return s;
    endfunction

    function automatic logic [71:0] win(int a, int step);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(a + step * k);
        return r;
    endfunction

    // pixel model: accumulate at acceptance, release the result after 3 more advancing edges
    typedef struct { int due; bit last; longint val; } item_t;
    item_t  pq [3][$];
    item_t  it;
    int     cnt [3];
    int     adv [3];
    longint acc [3];
    longint mres [3];
    bit     mov [3];
    bit     chk_on = 1'b0;
    longint rq [3][$];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cnt[i] = 0; acc[i] = 0; adv[i] = 0; mov[i] = 0; mres[i] = 0;
                pq[i].delete();
            end else if (!(mov[i] && !ordy)) begin
                adv[i]++;
                mov[i] = 0;
                if (pq[i].size() != 0 && pq[i][0].due == adv[i]) begin
                    it = pq[i].pop_front();
                    mov[i] = it.last;
                    if (it.last) mres[i] = it.val;
                end
                if (vld) begin
                    acc[i]  = (cnt[i] == 0 ? 0 : acc[i]) + dot();
                    it.due  = adv[i] + 3;
                    it.last = cnt[i] == ich(i) - 1;
                    it.val  = fin(i, acc[i] + longint'($signed(bi)));
                    pq[i].push_back(it);
                    cnt[i] = it.last ? 0 : cnt[i] + 1;
                end
            end
        end
        chk_on = chk_on | rst;
    end

    task automatic chk(string nm, int i, longint a, longint e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, i, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                chk("o_valid", i, longint'(dv[i]), longint'(mov[i]));
                if (mov[i]) chk("o_result", i, longint'(dr[i]), mres[i]);
                chk("i_ready", i, longint'(drdy[i]), longint'(!(mov[i] && !ordy)));
                chk("o_busy", i, longint'(db[i]), longint'(cnt[i] != 0 || pq[i].size() != 0));
                if (dv[i] && ordy && !rst) rq[i].push_back(longint'(dr[i]));
            end
        end
    end

    task automatic rchk(string nm, int i, int idx, longint e);
        chk(nm, i, rq[i].size() > idx ? rq[i][idx] : -1000000, e);
    endtask

    // all drivers run at posedge+2; rst wins over the beat presented in the same cycle
    task automatic do_rst();
        rst = 1'b1; vld = 1'b0; ordy = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) rq[i].delete();
    endtask

    task automatic beat(logic [71:0] f, logic [71:0] w, int b);
        int n = 0;
        bit ok = 1'b0;
        vld = 1'b1; fm = f; wt = w; bi = 16'(b);
        while (!ok && n < 40) begin
            #1 ok = if1.i_ready;
            @(posedge clk); #2;
            n++;
        end
        if (!ok) chk("beat_timeout", 1, 0, 1);
    endtask

    task automatic idle(int n);
        vld = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic signed [15:0] r0;
        do_rst();
        beat(win(1, 1), win(9, -1), 0);
        idle(8);
        rchk("dot_165", 0, 0, 165);
        rchk("sat8_165", 2, 0, 127);
        chk("ich4_no_early", 1, rq[1].size(), 0);

        do_rst();
        repeat (4) beat(win(1, 1), win(9, -1), 10);
        idle(8);
        chk("ich4_one_result", 1, rq[1].size(), 1);
        rchk("ich4_670", 1, 0, 670);
        rchk("ich1_175", 0, 3, 175);
        rchk("sat8_175", 2, 3, 127);

        do_rst();
        beat(win(1, 0), win(-1, 0), 0);
        idle(8);
        rchk("relu_0", 0, 0, 0);
        rchk("norelu_m9", 2, 0, -9);

        do_rst();
        beat(win(127, 0), win(127, 0), 0);
        beat(win(127, 0), win(-128, 0), 0);
        idle(8);
        rchk("sat16_pos", 0, 0, 32767);
        rchk("relu_neg", 0, 1, 0);
        rchk("sat8_pos", 2, 0, 127);
        rchk("sat8_neg", 2, 1, -128);

        do_rst();
        repeat (4) beat(win(1, 1), win(9, -1), 10);
        ordy = 1'b0;
        fork
            begin
                repeat (3) beat(win(2, 0), win(3, 0), 99);
                beat(win(2, 0), win(3, 0), -16);
            end
            begin
                n = 0;
                while (!if1.o_valid && n < 20) begin @(posedge clk); #2; n++; end
                chk("stall_ovalid_seen", 1, longint'(if1.o_valid), 1);
                r0 = dr[1];
                repeat (5) begin
                    chk("stall_i_ready", 1, longint'(if1.i_ready), 0);
                    chk("stall_hold", 1, longint'(dr[1]), longint'(r0));
                    @(posedge clk); #2;
                end
                ordy = 1'b1;
            end
        join
        idle(10);
        chk("stall_count", 1, rq[1].size(), 2);
        rchk("stall_first", 1, 0, 670);
        rchk("stall_second", 1, 1, 200);

        do_rst();
        repeat (2) beat(win(5, 1), win(1, 1), 0);
        do_rst();
        repeat (3) beat(win(1, 0), win(1, 1), 77);
        beat(win(1, 0), win(1, 1), 5);
        idle(8);
        chk("rst_one_result", 1, rq[1].size(), 1);
        rchk("rst_fresh_185", 1, 0, 185);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cnn_channel_acc.md
CNN_CHANNEL_ACC -- requirements
Module: cnn_channel_acc

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  KW, 3, kernel width; KH, 3, kernel height; ICH, 4, input channels per output pixel;
  IF_BW, 8, fmap element width; W_BW, 8, weight element width; B_BW, 16, bias width;
  O_BW, 16, output width; RELU_EN, 1, 1 = clamp negative results to 0.
REQ-002 Derived widths SHALL be: M_BW=IF_BW+W_BW; AC_BW=M_BW+clog2(KW*KH); CH_BW=AC_BW+clog2(ICH); BA_BW=max(CH_BW,B_BW)+1.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  i_valid  in  1  input beat valid
  i_ready  out  1  block accepts a beat this cycle
  i_fmap  in  KW*KH*IF_BW  one channel's window, element 0 in LSBs
  i_weight  in  KW*KH*W_BW  matching weights, element 0 in LSBs
  i_bias  in  B_BW  bias, sampled on the last-channel beat only
  o_valid  out  1  o_result valid
  o_ready  in  1  downstream accepts o_result
  o_result  out  O_BW  finished output pixel
  o_busy  out  1  partial pixel or pipeline data in flight
REQ-004 All data SHALL be signed two's complement.

Function
REQ-005 A beat SHALL be accepted when i_valid && i_ready.
REQ-006 stall SHALL be o_valid && !o_ready; i_ready SHALL equal !stall; on stall every pipeline register, counter and accumulator SHALL hold.
REQ-007 Stage 1 SHALL register the KW*KH products (M_BW each) with first/last tags and the bias.
REQ-008 Stage 2 SHALL register the adder-tree sum of the products, sign-extended to AC_BW, with tags.
REQ-009 Stage 3 SHALL register the channel accumulator (CH_BW): load the sum on a first-tagged beat, otherwise add the sum.
REQ-010 Output stage SHALL compute acc+bias in BA_BW, apply ReLU if RELU_EN, saturate to the signed O_BW range, and register into o_result with o_valid=1.
REQ-011 A channel counter (0..ICH-1) SHALL increment per accepted beat, wrap to 0 after ICH-1, and tag beats first (count 0) and last (count ICH-1); ICH=1 tags every beat as both.
REQ-012 Latency SHALL be 4 cycles from the accepted last-channel beat to o_valid, excluding stall cycles.
REQ-013 o_valid SHALL stay high with o_result stable until o_ready is sampled high; it SHALL fall the cycle after the handshake unless a new result lands that same cycle.
REQ-014 Back-to-back pixels SHALL run at full throughput: a first-tagged beat may follow a last-tagged beat on the next cycle with no corruption.
REQ-015 Non-last beats SHALL NOT assert o_valid.
REQ-016 o_busy SHALL be 1 whenever the channel counter is nonzero or any stage 1-3 tag is valid.

Reset
REQ-017 On rst, the channel counter, all stage valid tags, accumulator, o_valid and o_result SHALL be cleared to 0; i_ready SHALL be 1 and o_busy 0 in the first cycle after reset.
REQ-018 rst mid-pixel SHALL discard the partial pixel; the first beat after reset SHALL be treated as channel 0.
REQ-019 rst SHALL take priority over stall and over any accepted beat in the same cycle.

Verification
REQ-020 ICH=1, fmap elements 1..9, weights 9..1, bias 0, o_ready=1 -> o_result=165, o_valid pulse 4 cycles after the beat.
REQ-021 ICH=4, same window on 4 consecutive beats, bias 10 -> single o_result=670 after the 4th beat, no o_valid earlier.
REQ-022 RELU_EN=1, weights all -1, fmap all 1, ICH=1, bias 0 -> o_result=0; with RELU_EN=0 -> o_result=-9.
REQ-023 O_BW=8, fmap all 127, weights all 127, ICH=1 -> o_result=127 (saturated); all -128 weights with fmap 127 and RELU_EN=0 -> -128.
REQ-024 o_ready held 0 for 5 cycles while o_valid=1 and i_valid=1 -> i_ready=0, o_result stable, no beats lost; results in order after release.
REQ-025 rst pulsed after 2 of 4 channel beats, then 4 fresh beats -> exactly one o_result equal to the fresh pixel only.
